// File: rtl/taxi_axil_regfile_pkg.sv
// Shared types for the AXI-Lite register file: response codes, register classes and the
// address-to-class decoder.
package taxi_axil_regfile_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ClassRw,
        ClassRo,
        ClassUnmapped
    } reg_class_t;

    // RW registers occupy the low word indices, RO registers follow, the rest is unmapped.
    function automatic reg_class_t decode(
        input longint unsigned idx,
        input longint unsigned rw_count,
        input longint unsigned ro_count
    );
        if (idx < rw_count) begin
            return ClassRw;
        end
        if (idx < rw_count + ro_count) begin
            return ClassRo;
        end
        return ClassUnmapped;
    endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// Minimal AXI4-Lite interface with separate write and read modports.
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport wr_mst (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport wr_slv (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
    modport rd_mst (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );
    modport rd_slv (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/taxi_axil_regfile.sv
// AXI4-Lite responder terminating writes and reads into RW control and RO status registers,
// with one-cycle access pulses toward local logic.
module taxi_axil_regfile
    import taxi_axil_regfile_pkg::*;
#(
    parameter int unsigned RW_COUNT = 8,
    parameter int unsigned RO_COUNT = 8,
    parameter int unsigned DATA_W = 32,
    parameter CTRL_RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    taxi_axil_if.wr_slv                  s_axil_wr,
    taxi_axil_if.rd_slv                  s_axil_rd,
    output logic [RW_COUNT*DATA_W-1:0]   ctrl_reg,
    output logic [RW_COUNT-1:0]          ctrl_wr_pulse,
    input  logic [RO_COUNT*DATA_W-1:0]   status_reg,
    output logic [RO_COUNT-1:0]          status_rd_pulse
);

    localparam int unsigned ADDR_W = s_axil_wr.ADDR_W;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned CTRL_W = RW_COUNT * DATA_W;
    localparam logic [CTRL_W-1:0] RESET_IMG = CTRL_W'(CTRL_RESET_VAL);

    logic                aw_held_q, aw_held_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                w_held_q, w_held_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    resp_t               bresp_q, bresp_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [RW_COUNT-1:0] wr_pulse_q, wr_pulse_d;

    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    resp_t               rresp_q, rresp_d;
    logic [RO_COUNT-1:0] rd_pulse_q, rd_pulse_d;

    logic              commit;
    logic              ar_ready;
    logic              ar_hs;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    reg_class_t        wr_class, rd_class;
    logic              unused_prot;

    assign unused_prot = ^{s_axil_wr.awprot, s_axil_rd.arprot};

    assign wr_idx   = awaddr_q >> ADDR_LSB;
    assign wr_class = decode(64'(wr_idx), 64'(RW_COUNT), 64'(RO_COUNT));
    assign commit   = aw_held_q && w_held_q && !bvalid_q;

    assign rd_idx   = s_axil_rd.araddr >> ADDR_LSB;
    assign rd_class = decode(64'(rd_idx), 64'(RW_COUNT), 64'(RO_COUNT));
    assign ar_ready = !rvalid_q || s_axil_rd.rready;
    assign ar_hs    = s_axil_rd.arvalid && ar_ready;

    assign s_axil_wr.awready = !aw_held_q;
    assign s_axil_wr.wready  = !w_held_q;
    assign s_axil_wr.bvalid  = bvalid_q;
    assign s_axil_wr.bresp   = bresp_q;
    assign s_axil_rd.arready = ar_ready;
    assign s_axil_rd.rvalid  = rvalid_q;
    assign s_axil_rd.rdata   = rdata_q;
    assign s_axil_rd.rresp   = rresp_q;

    assign ctrl_reg        = ctrl_q;
    assign ctrl_wr_pulse   = wr_pulse_q;
    assign status_rd_pulse = rd_pulse_q;

    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;

        if (bvalid_q && s_axil_wr.bready) begin
            bvalid_d = 1'b0;
        end
        if (s_axil_wr.awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axil_wr.awaddr;
        end
        if (s_axil_wr.wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axil_wr.wdata;
            wstrb_d  = s_axil_wr.wstrb;
        end

        // Both buffers are full here, so neither can be refilled on the commit edge.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            case (wr_class)
                ClassRw: begin
                    bresp_d = RespOkay;
                    for (int unsigned i = 0; i < RW_COUNT; i++) begin
                        if (wr_idx == ADDR_W'(i)) begin
                            wr_pulse_d[i] = 1'b1;
                            for (int unsigned b = 0; b < STRB_W; b++) begin
                                if (wstrb_q[b]) begin
                                    ctrl_d[i*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                ClassRo: bresp_d = RespSlverr;
                default: bresp_d = RespDecerr;
            endcase
        end
    end

    always_comb begin
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;

        if (rvalid_q && s_axil_rd.rready) begin
            rvalid_d = 1'b0;
        end
        // ctrl_q is the pre-commit value, so a read racing a write sees the old data.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            case (rd_class)
                ClassRw: begin
                    rresp_d = RespOkay;
                    for (int unsigned i = 0; i < RW_COUNT; i++) begin
                        if (rd_idx == ADDR_W'(i)) begin
                            rdata_d = ctrl_q[i*DATA_W +: DATA_W];
                        end
                    end
                end
                ClassRo: begin
                    rresp_d = RespOkay;
                    for (int unsigned j = 0; j < RO_COUNT; j++) begin
                        if (rd_idx == ADDR_W'(RW_COUNT + j)) begin
                            rdata_d       = status_reg[j*DATA_W +: DATA_W];
                            rd_pulse_d[j] = 1'b1;
                        end
                    end
                end
                default: rresp_d = RespDecerr;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            ctrl_q     <= RESET_IMG;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
            rd_pulse_q <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

endmodule

// File: tb/tb_taxi_axil_regfile.sv
// Self-checking bench for taxi_axil_regfile: directed scenarios plus randomized traffic scored
// against a word-array model of the register map.
module tb_taxi_axil_regfile;

    localparam int RW = 8;
    localparam int RO = 8;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam logic [RW*DW-1:0] RESET_VAL = {32'h0, 32'h0, 32'h0, 32'h0,
                                              32'h0, 32'hCAFEF00D, 32'h0, 32'h12345678};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [RW*DW-1:0] ctrl_reg;
    logic [RW-1:0]    ctrl_wr_pulse;
    logic [RO*DW-1:0] status_reg;
    logic [RO-1:0]    status_rd_pulse;

    taxi_axil_if #(.DATA_W(DW), .ADDR_W(AW)) axil ();

    taxi_axil_regfile #(
        .RW_COUNT(RW),
        .RO_COUNT(RO),
        .DATA_W(DW),
        .CTRL_RESET_VAL(RESET_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axil_wr(axil),
        .s_axil_rd(axil),
        .ctrl_reg(ctrl_reg),
        .ctrl_wr_pulse(ctrl_wr_pulse),
        .status_reg(status_reg),
        .status_rd_pulse(status_rd_pulse)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] ctrl_m [RW];
    logic [31:0] stat_m [RO];

    function automatic void reset_model();
        logic [RW*DW-1:0] img;
        img = RESET_VAL;
        for (int i = 0; i < RW; i++) ctrl_m[i] = img[i*32 +: 32];
    endfunction

    function automatic logic [RW*DW-1:0] model_image();
        logic [RW*DW-1:0] img;
        for (int i = 0; i < RW; i++) img[i*32 +: 32] = ctrl_m[i];
        return img;
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [31:0] d,
                                        input logic [3:0] s, output logic [1:0] resp,
                                        output logic [RW-1:0] pulse);
        int idx;
        idx = int'(addr) / 4;
        pulse = '0;
        if (idx < RW) begin
            for (int b = 0; b < 4; b++) if (s[b]) ctrl_m[idx][b*8 +: 8] = d[b*8 +: 8];
            pulse = RW'(1) << idx;
            resp = 2'b00;
        end else if (idx < RW + RO) begin
            resp = 2'b10;
        end else begin
            resp = 2'b11;
        end
    endfunction

    function automatic void model_read(input logic [15:0] addr, output logic [31:0] d,
                                       output logic [1:0] resp, output logic [RO-1:0] pulse);
        int idx;
        idx = int'(addr) / 4;
        pulse = '0;
        d = '0;
        resp = 2'b11;
        if (idx < RW) begin
            d = ctrl_m[idx];
            resp = 2'b00;
        end else if (idx < RW + RO) begin
            d = stat_m[idx-RW];
            pulse = RO'(1) << (idx - RW);
            resp = 2'b00;
        end
    endfunction

    task automatic apply_status();
        for (int j = 0; j < RO; j++) status_reg[j*32 +: 32] = stat_m[j];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [RW-1:0] pulse,
                            output bit ok);
        axil.awaddr = addr;
        axil.awprot = 3'($urandom);
        axil.awvalid = 1'b1;
        axil.wdata = d;
        axil.wstrb = s;
        axil.wvalid = 1'b1;
        axil.bready = 1'b1;
        ok = 1'b0;
        resp = 2'bxx;
        pulse = 'x;
        for (int n = 0; n < 20 && (axil.awvalid || axil.wvalid); n++) begin
            logic ha, hw;
            ha = axil.awvalid && axil.awready;
            hw = axil.wvalid && axil.wready;
            cycle();
            if (ha) axil.awvalid = 1'b0;
            if (hw) axil.wvalid = 1'b0;
        end
        if (!axil.awvalid && !axil.wvalid) begin
            for (int n = 0; n < 20; n++) begin
                if (axil.bvalid) begin
                    ok = 1'b1;
                    break;
                end
                cycle();
            end
        end
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        resp = axil.bresp;
        pulse = ctrl_wr_pulse;
        cycle();
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [31:0] d,
                           output logic [1:0] resp, output logic [RO-1:0] pulse, output bit ok);
        axil.araddr = addr;
        axil.arprot = 3'($urandom);
        axil.arvalid = 1'b1;
        axil.rready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (axil.arready) break;
            cycle();
        end
        cycle();
        axil.arvalid = 1'b0;
        ok = axil.rvalid;
        d = axil.rdata;
        resp = axil.rresp;
        pulse = status_rd_pulse;
        cycle();
    endtask

    task automatic test_reset();
        logic [31:0] ed;
        logic [1:0] er;
        logic [RO-1:0] ep;
        total++; if (axil.awready !== 1'b1 || axil.wready !== 1'b1)
            $display("FAIL reset_wr_ready: aw=%b w=%b want 1 1", axil.awready, axil.wready);
            else passed++;
        total++; if (axil.bvalid !== 1'b0 || axil.bresp !== 2'b00)
            $display("FAIL reset_b: bvalid=%b bresp=%b want 0 00", axil.bvalid, axil.bresp);
            else passed++;
        total++; if (axil.arready !== 1'b1 || axil.rvalid !== 1'b0)
            $display("FAIL reset_rd: arready=%b rvalid=%b want 1 0", axil.arready, axil.rvalid);
            else passed++;
        total++; if (axil.rdata !== 32'h0 || axil.rresp !== 2'b00)
            $display("FAIL reset_rdata: %h/%b want 0/00", axil.rdata, axil.rresp); else passed++;
        total++; if (ctrl_reg !== RESET_VAL)
            $display("FAIL reset_ctrl: got %h want %h", ctrl_reg, RESET_VAL); else passed++;
        total++; if (ctrl_wr_pulse !== '0 || status_rd_pulse !== '0)
            $display("FAIL reset_pulses: %b %b want 0", ctrl_wr_pulse, status_rd_pulse);
            else passed++;
        rst = 1'b0;
        cycle();
        model_read(16'h0000, ed, er, ep);
        axil.araddr = 16'h0000;
        axil.arvalid = 1'b1;
        axil.rready = 1'b1;
        cycle();
        axil.arvalid = 1'b0;
        total++; if (axil.rvalid !== 1'b1)
            $display("FAIL first_read_latency: rvalid=%b want 1", axil.rvalid); else passed++;
        total++; if (axil.rdata !== ed || axil.rresp !== er)
            $display("FAIL first_read_data: %h/%b want %h/%b", axil.rdata, axil.rresp, ed, er);
            else passed++;
        cycle();
        total++; if (axil.rvalid !== 1'b0)
            $display("FAIL first_read_done: rvalid=%b want 0", axil.rvalid); else passed++;
    endtask

    task automatic test_write_order();
        logic [1:0] er;
        logic [RW-1:0] ep;
        int bcount;
        axil.bready = 1'b0;
        axil.wdata = 32'hDEADBEEF;
        axil.wstrb = 4'b0101;
        axil.wvalid = 1'b1;
        cycle();
        axil.wvalid = 1'b0;
        total++; if (axil.wready !== 1'b0 || axil.awready !== 1'b1)
            $display("FAIL w_first_ready: w=%b aw=%b want 0 1", axil.wready, axil.awready);
            else passed++;
        cycle();
        cycle();
        axil.awaddr = 16'h0004;
        axil.awvalid = 1'b1;
        cycle();
        axil.awvalid = 1'b0;
        total++; if (axil.bvalid !== 1'b0)
            $display("FAIL w_first_early_b: bvalid=%b want 0", axil.bvalid); else passed++;
        cycle();
        model_write(16'h0004, 32'hDEADBEEF, 4'b0101, er, ep);
        total++; if (axil.bvalid !== 1'b1 || axil.bresp !== er)
            $display("FAIL w_first_b: %b/%b want 1/%b", axil.bvalid, axil.bresp, er);
            else passed++;
        total++; if (ctrl_reg[63:32] !== 32'h00AD00EF || ctrl_reg !== model_image())
            $display("FAIL w_first_data: reg1=%h want 00ad00ef", ctrl_reg[63:32]); else passed++;
        total++; if (ctrl_wr_pulse !== ep)
            $display("FAIL w_first_pulse: %b want %b", ctrl_wr_pulse, ep); else passed++;
        axil.bready = 1'b1;
        cycle();
        total++; if (ctrl_wr_pulse !== '0)
            $display("FAIL w_first_pulse_len: %b want 0", ctrl_wr_pulse); else passed++;
        bcount = 0;
        for (int n = 0; n < 4; n++) begin
            if (axil.bvalid) bcount++;
            cycle();
        end
        total++; if (bcount != 0)
            $display("FAIL w_first_extra_b: got %0d extra B want 0", bcount); else passed++;
    endtask

    task automatic test_errors();
        logic [1:0] er, gr;
        logic [RW-1:0] ep, gp;
        logic [31:0] ed, gd;
        logic [RO-1:0] eq, gq;
        bit ok;
        do_write(16'h0020, 32'h55AA55AA, 4'hF, gr, gp, ok);
        model_write(16'h0020, 32'h55AA55AA, 4'hF, er, ep);
        total++; if (!ok || gr !== er || gp !== ep || ctrl_reg !== model_image())
            $display("FAIL wr_ro: ok=%0d resp=%b pulse=%b want %b %b", ok, gr, gp, er, ep);
            else passed++;
        do_write(16'h0040, 32'h11223344, 4'hF, gr, gp, ok);
        model_write(16'h0040, 32'h11223344, 4'hF, er, ep);
        total++; if (!ok || gr !== er || gp !== ep || ctrl_reg !== model_image())
            $display("FAIL wr_unmapped: ok=%0d resp=%b pulse=%b want %b %b", ok, gr, gp, er, ep);
            else passed++;
        do_read(16'h0040, gd, gr, gq, ok);
        model_read(16'h0040, ed, er, eq);
        total++; if (!ok || gd !== ed || gr !== er || gq !== eq)
            $display("FAIL rd_unmapped: ok=%0d %h/%b want %h/%b", ok, gd, gr, ed, er);
            else passed++;
    endtask

    task automatic test_random();
        logic [15:0] addr;
        logic [31:0] d, ed, gd;
        logic [3:0] s;
        logic [1:0] er, gr;
        logic [RW-1:0] ep, gp;
        logic [RO-1:0] eq, gq;
        bit ok;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < RO; j++) stat_m[j] = $urandom;
            apply_status();
            addr = 16'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom);
                do_write(addr, d, s, gr, gp, ok);
                model_write(addr, d, s, er, ep);
                total++; if (!ok || gr !== er || gp !== ep || ctrl_reg !== model_image())
                    $display("FAIL rand_wr[%0d] a=%h: ok=%0d resp=%b pulse=%b want %b %b",
                             it, addr, ok, gr, gp, er, ep);
                    else passed++;
            end else begin
                do_read(addr, gd, gr, gq, ok);
                model_read(addr, ed, er, eq);
                total++; if (!ok || gd !== ed || gr !== er || gq !== eq)
                    $display("FAIL rand_rd[%0d] a=%h: ok=%0d %h/%b p=%b want %h/%b p=%b",
                             it, addr, ok, gd, gr, gq, ed, er, eq);
                    else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] er1, er2;
        logic [RW-1:0] ep1, ep2;
        axil.bready = 1'b0;
        axil.awaddr = 16'h0008;
        axil.wdata = 32'hA5A5_0001;
        axil.wstrb = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid = 1'b1;
        cycle();
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        cycle();
        model_write(16'h0008, 32'hA5A5_0001, 4'hF, er1, ep1);
        total++; if (axil.bvalid !== 1'b1 || axil.bresp !== er1)
            $display("FAIL bp_first_b: %b/%b want 1/%b", axil.bvalid, axil.bresp, er1);
            else passed++;
        axil.awaddr = 16'h000C;
        axil.wdata = 32'h5A5A_0002;
        axil.awvalid = 1'b1;
        axil.wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            axil.awvalid = 1'b0;
            axil.wvalid = 1'b0;
            total++; if (axil.bvalid !== 1'b1 || axil.bresp !== er1 ||
                         axil.awready !== 1'b0 || axil.wready !== 1'b0)
                $display("FAIL bp_hold[%0d]: bvalid=%b bresp=%b aw=%b w=%b want 1 %b 0 0",
                         k, axil.bvalid, axil.bresp, axil.awready, axil.wready, er1);
                else passed++;
        end
        total++; if (ctrl_reg !== model_image())
            $display("FAIL bp_no_early_commit: %h want %h", ctrl_reg, model_image());
            else passed++;
        axil.bready = 1'b1;
        cycle();
        total++; if (axil.bvalid !== 1'b0)
            $display("FAIL bp_release: bvalid=%b want 0", axil.bvalid); else passed++;
        cycle();
        model_write(16'h000C, 32'h5A5A_0002, 4'hF, er2, ep2);
        total++; if (axil.bvalid !== 1'b1 || axil.bresp !== er2 || ctrl_wr_pulse !== ep2 ||
                     ctrl_reg !== model_image())
            $display("FAIL bp_second_b: %b/%b pulse=%b want 1/%b %b",
                     axil.bvalid, axil.bresp, ctrl_wr_pulse, er2, ep2);
            else passed++;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic [1:0] er;
        logic [RO-1:0] eq;
        stat_m[0] = 32'hA;
        stat_m[1] = 32'hB;
        apply_status();
        axil.rready = 1'b1;
        axil.araddr = 16'h0020;
        axil.arvalid = 1'b1;
        cycle();
        axil.araddr = 16'h0024;
        total++; if (axil.rvalid !== 1'b1 || axil.rdata !== 32'hA || status_rd_pulse !== 8'h01)
            $display("FAIL b2b_first: %b %h p=%b want 1 a 01",
                     axil.rvalid, axil.rdata, status_rd_pulse);
            else passed++;
        cycle();
        total++; if (axil.rvalid !== 1'b1 || axil.rdata !== 32'hB || status_rd_pulse !== 8'h02)
            $display("FAIL b2b_second: %b %h p=%b want 1 b 02",
                     axil.rvalid, axil.rdata, status_rd_pulse);
            else passed++;
        axil.araddr = 16'h0000;
        axil.rready = 1'b0;
        #1;
        total++; if (axil.arready !== 1'b0)
            $display("FAIL b2b_stall_arready: %b want 0", axil.arready); else passed++;
        cycle();
        total++; if (axil.rvalid !== 1'b1 || axil.rdata !== 32'hB || status_rd_pulse !== '0)
            $display("FAIL b2b_stall_hold: %b %h p=%b want 1 b 0",
                     axil.rvalid, axil.rdata, status_rd_pulse);
            else passed++;
        axil.rready = 1'b1;
        cycle();
        axil.arvalid = 1'b0;
        model_read(16'h0000, ed, er, eq);
        total++; if (axil.rvalid !== 1'b1 || axil.rdata !== ed || axil.rresp !== er)
            $display("FAIL b2b_resume: %b %h/%b want 1 %h/%b",
                     axil.rvalid, axil.rdata, axil.rresp, ed, er);
            else passed++;
        cycle();
    endtask

    task automatic test_simultaneous();
        logic [31:0] old, d, gd;
        logic [1:0] er, gr;
        logic [RW-1:0] ep;
        logic [RO-1:0] gq;
        bit ok;
        d = $urandom;
        old = ctrl_m[4];
        axil.bready = 1'b1;
        axil.awaddr = 16'h0010;
        axil.wdata = d;
        axil.wstrb = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid = 1'b1;
        cycle();
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        axil.araddr = 16'h0010;
        axil.arvalid = 1'b1;
        axil.rready = 1'b1;
        cycle();
        axil.arvalid = 1'b0;
        model_write(16'h0010, d, 4'hF, er, ep);
        total++; if (axil.rvalid !== 1'b1 || axil.rdata !== old || axil.bvalid !== 1'b1)
            $display("FAIL sim_rd_old: rvalid=%b rdata=%h bvalid=%b want 1 %h 1",
                     axil.rvalid, axil.rdata, axil.bvalid, old);
            else passed++;
        cycle();
        do_read(16'h0010, gd, gr, gq, ok);
        total++; if (!ok || gd !== d || gr !== 2'b00)
            $display("FAIL sim_rd_new: ok=%0d %h/%b want %h/00", ok, gd, gr, d); else passed++;
    endtask

    task automatic test_reset_mid();
        int bcount;
        axil.bready = 1'b0;
        axil.awaddr = 16'h0014;
        axil.wdata = 32'h0BAD_F00D;
        axil.wstrb = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid = 1'b1;
        cycle();
        axil.awvalid = 1'b0;
        axil.wvalid = 1'b0;
        cycle();
        total++; if (axil.bvalid !== 1'b1)
            $display("FAIL rstmid_pre_b: bvalid=%b want 1", axil.bvalid); else passed++;
        axil.awaddr = 16'h0018;
        axil.awvalid = 1'b1;
        cycle();
        axil.awvalid = 1'b0;
        total++; if (axil.awready !== 1'b0)
            $display("FAIL rstmid_aw_held: awready=%b want 0", axil.awready); else passed++;
        #2;
        rst = 1'b1;
        #1;
        reset_model();
        total++; if (axil.bvalid !== 1'b0 || axil.awready !== 1'b1 || axil.wready !== 1'b1)
            $display("FAIL rstmid_async: bvalid=%b aw=%b w=%b want 0 1 1",
                     axil.bvalid, axil.awready, axil.wready);
            else passed++;
        total++; if (ctrl_reg !== model_image())
            $display("FAIL rstmid_ctrl: %h want %h", ctrl_reg, model_image()); else passed++;
        cycle();
        cycle();
        rst = 1'b0;
        axil.bready = 1'b1;
        axil.wdata = 32'h7777_7777;
        axil.wvalid = 1'b1;
        bcount = 0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            axil.wvalid = 1'b0;
            if (axil.bvalid) bcount++;
        end
        total++; if (bcount != 0 || ctrl_reg !== model_image())
            $display("FAIL rstmid_no_resp: %0d B seen, ctrl=%h want 0 B", bcount, ctrl_reg);
            else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axil.awaddr = '0;
        axil.awprot = '0;
        axil.awvalid = 1'b0;
        axil.wdata = '0;
        axil.wstrb = '0;
        axil.wvalid = 1'b0;
        axil.bready = 1'b0;
        axil.araddr = '0;
        axil.arprot = '0;
        axil.arvalid = 1'b0;
        axil.rready = 1'b1;
        for (int j = 0; j < RO; j++) stat_m[j] = 32'h0;
        apply_status();
        reset_model();
        rst = 1'b1;
        repeat (3) cycle();
        test_reset();
        test_write_order();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
